// File: rtl/ex_mem_branch_stage_if.sv
// EX -> MEM pipeline bundle: EX-stage inputs, hazard controls and MEM-stage outputs.
// BRANCH_STATS_EN adds the BranchCount/TakenCount outputs.
interface ex_mem_branch_stage_if #(parameter int DATA_W = 32);
    logic              Stall, Flush, ValidEx;
    logic [DATA_W-1:0] outAddEx, AluResult, WriteDataEx;
    logic              Zero;
    logic [4:0]        RegDstEx;
    logic              BranchEx, BneEx, MemReadEx, MemWriteEx, RegWriteEx, MemToRegEx;

    logic              ValidMem;
    logic [DATA_W-1:0] BranchTargetMem, AluResultMem, WriteDataMem;
    logic [4:0]        RegDstMem;
    logic              MemReadMem, MemWriteMem, RegWriteMem, MemToRegMem;
    logic              PcSrc, SquashActive;
`ifdef BRANCH_STATS_EN
    logic [15:0]       BranchCount, TakenCount;
`endif

    modport master (
        output Stall, Flush, ValidEx, outAddEx, AluResult, WriteDataEx, Zero, RegDstEx,
               BranchEx, BneEx, MemReadEx, MemWriteEx, RegWriteEx, MemToRegEx,
        input  ValidMem, BranchTargetMem, AluResultMem, WriteDataMem, RegDstMem,
               MemReadMem, MemWriteMem, RegWriteMem, MemToRegMem, PcSrc, SquashActive
`ifdef BRANCH_STATS_EN
      , input  BranchCount, TakenCount
`endif
    );

    modport slave (
        input  Stall, Flush, ValidEx, outAddEx, AluResult, WriteDataEx, Zero, RegDstEx,
               BranchEx, BneEx, MemReadEx, MemWriteEx, RegWriteEx, MemToRegEx,
        output ValidMem, BranchTargetMem, AluResultMem, WriteDataMem, RegDstMem,
               MemReadMem, MemWriteMem, RegWriteMem, MemToRegMem, PcSrc, SquashActive
`ifdef BRANCH_STATS_EN
      , output BranchCount, TakenCount
`endif
    );
endinterface

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with MEM-stage beq/bne resolution and wrong-path squash.
// Optional macro BRANCH_STATS_EN adds 16-bit branch / taken-branch counters.
module ex_mem_branch_stage #(
    parameter int SQUASH_DEPTH = 3,
    parameter int DATA_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    ex_mem_branch_stage_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] tgt;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wd;
        logic [4:0]        rd;
        logic              br, bne, zero, mr, mw, rw, m2r;
    } mem_t;

    localparam logic [2:0] SQ_RELOAD = 3'(SQUASH_DEPTH - 1);

    mem_t       mem_q, ex_d;
    logic [2:0] sq_cnt;
    logic       pc_src;

    always_comb begin
        ex_d       = '0;
        ex_d.valid = bus.ValidEx;
        ex_d.tgt   = bus.outAddEx;
        ex_d.alu   = bus.AluResult;
        ex_d.wd    = bus.WriteDataEx;
        ex_d.rd    = bus.RegDstEx;
        ex_d.br    = bus.BranchEx;
        ex_d.bne   = bus.BneEx;
        ex_d.zero  = bus.Zero;
        ex_d.mr    = bus.MemReadEx;
        ex_d.mw    = bus.MemWriteEx;
        ex_d.rw    = bus.RegWriteEx;
        ex_d.m2r   = bus.MemToRegEx;
    end

    // beq and bne both set: taken if either condition holds
    assign pc_src = mem_q.valid & ((mem_q.br & mem_q.zero) | (mem_q.bne & ~mem_q.zero));

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '0;
            sq_cnt <= '0;
        end else if (bus.Flush) begin
            mem_q  <= '0;
        end else if (!bus.Stall) begin
            if (pc_src || sq_cnt != 3'd0) begin
                mem_q  <= '0;
                sq_cnt <= pc_src ? SQ_RELOAD : sq_cnt - 3'd1;
            end else begin
                mem_q  <= ex_d;
            end
        end
    end

    assign bus.ValidMem        = mem_q.valid;
    assign bus.BranchTargetMem = mem_q.tgt;
    assign bus.AluResultMem    = mem_q.alu;
    assign bus.WriteDataMem    = mem_q.wd;
    assign bus.RegDstMem       = mem_q.rd;
    assign bus.MemReadMem      = mem_q.mr  & mem_q.valid;
    assign bus.MemWriteMem     = mem_q.mw  & mem_q.valid;
    assign bus.RegWriteMem     = mem_q.rw  & mem_q.valid;
    assign bus.MemToRegMem     = mem_q.m2r & mem_q.valid;
    assign bus.PcSrc           = pc_src;
    assign bus.SquashActive    = pc_src | (sq_cnt != 3'd0);

`ifdef BRANCH_STATS_EN
    logic [15:0] br_cnt, tk_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt <= '0;
            tk_cnt <= '0;
        end else if (!bus.Stall) begin
            if (mem_q.valid && (mem_q.br || mem_q.bne)) br_cnt <= br_cnt + 16'd1;
            if (pc_src)                                 tk_cnt <= tk_cnt + 16'd1;
        end
    end

    assign bus.BranchCount = br_cnt;
    assign bus.TakenCount  = tk_cnt;
`endif
endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Bench for ex_mem_branch_stage: vector table for single-cycle captures plus
// hand-written branch / squash / stall / flush / reset sequences via a scoreboard queue.
module tb_ex_mem_branch_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mem_branch_stage_if #(.DATA_W(32)) bus ();
    ex_mem_branch_stage #(.SQUASH_DEPTH(3), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    typedef struct {
        logic        v, z, br, bne, mr, mw, rw, m2r;
        logic [31:0] alu, wd, tgt;
        logic [4:0]  rd;
        logic        ev, epc;
        logic [3:0]  ectrl;   // {MemRead, MemWrite, RegWrite, MemToReg}
    } vec_t;

    typedef struct {
        logic        v, pc, sqa;
        logic [3:0]  ctrl;
        logic [31:0] alu, tgt, wd;
        logic [4:0]  rd;
    } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, pc, sqa, input logic [3:0] ctrl,
                                input logic [31:0] alu, tgt, wd, input logic [4:0] rd);
        exp_t e;
        e.v = v; e.pc = pc; e.sqa = sqa; e.ctrl = ctrl;
        e.alu = alu; e.tgt = tgt; e.wd = wd; e.rd = rd;
        return e;
    endfunction

    function automatic exp_t bubble(input logic sqa);
        return mk(1'b0, 1'b0, sqa, 4'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    endfunction

    task automatic set_ex(input logic v, z, br, bne, mr, mw, rw, m2r,
                          input logic [31:0] alu, wd, tgt, input logic [4:0] rd);
        bus.ValidEx = v; bus.Zero = z; bus.BranchEx = br; bus.BneEx = bne;
        bus.MemReadEx = mr; bus.MemWriteEx = mw; bus.RegWriteEx = rw; bus.MemToRegEx = m2r;
        bus.AluResult = alu; bus.WriteDataEx = wd; bus.outAddEx = tgt; bus.RegDstEx = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".ValidMem"},     {31'b0, bus.ValidMem},     {31'b0, e.v});
        chk({tag, ".PcSrc"},        {31'b0, bus.PcSrc},        {31'b0, e.pc});
        chk({tag, ".SquashActive"}, {31'b0, bus.SquashActive}, {31'b0, e.sqa});
        chk({tag, ".ctrl"}, {28'b0, bus.MemReadMem, bus.MemWriteMem, bus.RegWriteMem, bus.MemToRegMem},
            {28'b0, e.ctrl});
        chk({tag, ".AluResultMem"},    bus.AluResultMem,    e.alu);
        chk({tag, ".BranchTargetMem"}, bus.BranchTargetMem, e.tgt);
        chk({tag, ".WriteDataMem"},    bus.WriteDataMem,    e.wd);
        chk({tag, ".RegDstMem"},       {27'b0, bus.RegDstMem}, {27'b0, e.rd});
    endtask

    task automatic cyc(input string tag, input exp_t e);
        sb.push_back(e);
        step();
        pop_check(tag);
    endtask

    task automatic set_normal();
        set_ex(1, 0, 0, 0, 0, 0, 1, 0, 32'h11, 32'h0, 32'h0, 5'd7);
    endtask

    task automatic set_taken(input logic [31:0] tgt);
        set_ex(1, 1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, tgt, 5'd0);
    endtask

    vec_t vt[7];
    exp_t e_norm, e_stall;

    initial begin
        e_norm = mk(1, 0, 0, 4'b0010, 32'h11, 32'h0, 32'h0, 5'd7);

        //        v  z  br bne mr mw rw m2r alu           wd            tgt           rd    ev epc ctrl
        vt[0] = '{1, 0, 0, 0,  0, 0, 1, 0,  32'h0000_00A4, 32'h0,        32'h0,        5'd5,  1, 0, 4'b0010};
        vt[1] = '{1, 1, 0, 1,  0, 0, 0, 0,  32'h0,         32'h0,        32'h0000_0100, 5'd0, 1, 0, 4'b0000};
        vt[2] = '{0, 0, 0, 1,  0, 0, 0, 0,  32'h0,         32'h0,        32'h0000_0200, 5'd0, 0, 0, 4'b0000};
        vt[3] = '{0, 0, 0, 0,  0, 1, 0, 0,  32'h0000_1000, 32'h1234_5678, 32'h0,       5'd3,  0, 0, 4'b0000};
        vt[4] = '{1, 0, 0, 0,  1, 0, 1, 1,  32'hFFFF_FFFC, 32'h0,        32'h0,        5'd31, 1, 0, 4'b1011};
        vt[5] = '{1, 0, 1, 0,  0, 0, 0, 0,  32'h0,         32'h0,        32'hFFFF_FFF0, 5'd0, 1, 0, 4'b0000};
        vt[6] = '{1, 0, 0, 0,  0, 1, 0, 0,  32'h0000_0008, 32'hDEAD_BEEF, 32'h0,       5'd0,  1, 0, 4'b0100};

        // reset with every input high
        reset = 1'b1; bus.Stall = 1'b1; bus.Flush = 1'b1;
        set_ex(1, 1, 1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F);
        cyc("reset", bubble(0));
        reset = 1'b0; bus.Stall = 1'b0; bus.Flush = 1'b0;

        for (int i = 0; i < 7; i++) begin
            set_ex(vt[i].v, vt[i].z, vt[i].br, vt[i].bne, vt[i].mr, vt[i].mw, vt[i].rw, vt[i].m2r,
                   vt[i].alu, vt[i].wd, vt[i].tgt, vt[i].rd);
            cyc($sformatf("vec%0d", i),
                mk(vt[i].ev, vt[i].epc, 1'b0, vt[i].ectrl, vt[i].alu, vt[i].tgt, vt[i].wd, vt[i].rd));
        end

        // taken beq: one PcSrc cycle then three bubbles
        set_taken(32'h0000_0040);
        cyc("beq_taken", mk(1, 1, 1, 4'b0, 32'h0, 32'h40, 32'h0, 5'd0));
        set_normal();
        cyc("sq1", bubble(1));
        cyc("sq2", bubble(1));
        cyc("sq3", bubble(0));
        cyc("sq_done", e_norm);

        // beq+bne with Zero=0 is taken; held two cycles by Stall
        set_ex(1, 0, 1, 1, 0, 0, 0, 0, 32'h5, 32'h0, 32'h80, 5'd0);
        e_stall = mk(1, 1, 1, 4'b0, 32'h5, 32'h80, 32'h0, 5'd0);
        cyc("both_taken", e_stall);
        bus.Stall = 1'b1;
        set_normal();
        cyc("stall1", e_stall);
        cyc("stall2", e_stall);
        bus.Stall = 1'b0;
        cyc("stall_sq1", bubble(1));
        cyc("stall_sq2", bubble(1));
        cyc("stall_sq3", bubble(0));
        cyc("stall_done", e_norm);

        // Flush beats Stall on a valid store
        set_ex(1, 0, 0, 0, 0, 1, 0, 0, 32'h200, 32'hCAFE, 32'h0, 5'd0);
        bus.Stall = 1'b1; bus.Flush = 1'b1;
        cyc("flush_stall", bubble(0));
        bus.Stall = 1'b0; bus.Flush = 1'b0;

        // Flush alongside PcSrc: no squash reload
        set_taken(32'h0000_0044);
        cyc("fl_taken", mk(1, 1, 1, 4'b0, 32'h0, 32'h44, 32'h0, 5'd0));
        bus.Flush = 1'b1;
        set_normal();
        cyc("fl_pcsrc", bubble(0));
        bus.Flush = 1'b0;
        cyc("fl_done", e_norm);

        // reset mid-squash ends the squash
        set_taken(32'h0000_0048);
        cyc("rs_taken", mk(1, 1, 1, 4'b0, 32'h0, 32'h48, 32'h0, 5'd0));
        set_normal();
        cyc("rs_sq1", bubble(1));
        reset = 1'b1;
        cyc("rs_reset", bubble(0));
        reset = 1'b0;
        cyc("rs_done", e_norm);

`ifdef BRANCH_STATS_EN
        reset = 1'b1;
        cyc("st_reset", bubble(0));
        reset = 1'b0;
        chk("BranchCount_reset", {16'b0, bus.BranchCount}, 32'd0);
        chk("TakenCount_reset",  {16'b0, bus.TakenCount},  32'd0);
        set_taken(32'h10);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 4; i++) step();
        set_ex(1, 1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h20, 5'd0);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        step();
        set_taken(32'h30);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 4; i++) step();
        chk("BranchCount", {16'b0, bus.BranchCount}, 32'd3);
        chk("TakenCount",  {16'b0, bus.TakenCount},  32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_branch_stage.md
Name: ex_mem_branch_stage

Overview:
- EX/MEM pipeline register for the 5-stage MIPS pipeline; captures the EX-stage branch-target adder output, ALU result, zero flag, store data, destination register and control bits.
- Resolves beq/bne in MEM: drives PcSrc and the registered branch target to the IF-stage PC mux.
- After a taken branch, squashes the wrong-path instructions still in flight.
- Sits directly downstream of the EX branch-target adder and ALU, upstream of data memory.

Parameters:
- SQUASH_DEPTH, 3, number of consecutive EX-stage captures converted to bubbles after a taken branch (legal range 1..7).
- DATA_W, 32, width of the PC, target, ALU and store-data paths.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold all state this cycle.
- Flush  in  1  capture a bubble this cycle.
- ValidEx  in  1  EX-stage instruction is real.
- outAddEx  in  DATA_W  branch target (PostPc + shifted immediate) from the EX adder.
- AluResult  in  DATA_W  ALU output.
- Zero  in  1  ALU zero flag.
- WriteDataEx  in  DATA_W  store data (rt).
- RegDstEx  in  5  destination register number.
- BranchEx, BneEx  in  1 each  beq / bne decode.
- MemReadEx, MemWriteEx, RegWriteEx, MemToRegEx  in  1 each  control bits.
- ValidMem  out  1  MEM-stage instruction is real.
- BranchTargetMem, AluResultMem, WriteDataMem  out  DATA_W each  registered data.
- RegDstMem  out  5  registered destination register.
- MemReadMem, MemWriteMem, RegWriteMem, MemToRegMem  out  1 each  registered controls, gated by ValidMem.
- PcSrc  out  1  taken branch; selects BranchTargetMem at the PC mux.
- SquashActive  out  1  wrong-path squash in progress; upstream must not treat EX as committed.

Behaviour:
- Reset (highest priority): every registered field, including the squash counter, goes to 0. Consequently PcSrc=0 and SquashActive=0.
- Reset mid-squash: the squash counter goes to 0 and no further bubbles are inserted.
- Latency: 1 cycle from an EX input to the MEM output.
- Priority per rising edge: reset > Flush > Stall > squash > normal capture.
- Flush: load a bubble (all fields 0, ValidMem=0). Squash counter unchanged.
- Stall (without Flush): all registers and the squash counter hold. PcSrc stays asserted while a taken branch is held.
- Squash:
  - Condition: PcSrc=1 or sq_cnt!=0, with no Stall or Flush.
  - Action: load a bubble instead of the EX inputs.
  - If PcSrc=1: sq_cnt <= SQUASH_DEPTH-1.
  - Else: sq_cnt <= sq_cnt-1.
- Normal capture: all fields load from the EX inputs, ValidMem <= ValidEx.
- Control outputs are the registered bits AND ValidMem. An invalid slot never writes memory or registers.
- Taken condition (combinational from registered state): PcSrc = ValidMem & ((BranchMem & ZeroMem) | (BneMem & ~ZeroMem)).
  - Branch and Bne both set: treated as taken if either condition holds.
- SquashActive = PcSrc | (sq_cnt != 0).
- Wrap-around: BranchTargetMem is the 32-bit value as received; no overflow detection.
- A new taken branch cannot occur while sq_cnt!=0, because every capture in that window is a bubble.
- sq_cnt is 3 bits wide.
- Flush concurrent with PcSrc=1: the bubble loads and sq_cnt is not reloaded, since upstream is flushing.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds 16-bit outputs BranchCount and TakenCount, both reset to 0.
  - BranchCount increments on each non-stalled cycle where ValidMem & (BranchMem|BneMem).
  - TakenCount increments on each non-stalled cycle where PcSrc=1.
  - Both counters wrap at 0xFFFF -> 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with all inputs driven to 1 -> all outputs 0, PcSrc=0, SquashActive=0. Release, then capture ValidEx=1, AluResult=0x0000_00A4, RegWriteEx=1, RegDstEx=5 -> next cycle AluResultMem=0xA4, RegWriteMem=1, RegDstMem=5.
- beq with Zero=1, outAddEx=0x0000_0040, SQUASH_DEPTH=3 -> PcSrc=1 and BranchTargetMem=0x40 for 1 cycle; the next 3 captures are bubbles (ValidMem=0); SquashActive high for 3 cycles; the 4th capture passes.
- bne with Zero=1 -> PcSrc=0, no squash. bne with Zero=0, ValidEx=0 -> PcSrc=0.
- Taken branch held with Stall=1 for 2 cycles -> PcSrc stays 1 and sq_cnt does not change; on release the squash sequence proceeds as in scenario 2.
- Flush=1 with Stall=1 and a valid store in EX -> MemWriteMem=0, ValidMem=0. Reset asserted with sq_cnt=2 -> SquashActive=0 next cycle.
- With BRANCH_STATS_EN: 3 branches (2 taken) -> BranchCount=3, TakenCount=2. Preload near 0xFFFF and take 2 more -> TakenCount wraps to 0x0000 then 0x0001.
